// File: rtl/bar_rr_arb_if.sv
// Requester/consumer bundle for the round-robin arbiter: N valid/ready
// input channels, one registered output channel, and the transfer counter.
interface bar_rr_arb_if #(
    parameter int N  = 4,
    parameter int DW = 32
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   out_src;
    logic [15:0]     beat_cnt;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_src, beat_cnt
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_src, beat_cnt
    );
endinterface

// File: rtl/bar_rr_arb.sv
// N-way round-robin arbiter feeding a single registered output slot; full
// throughput when the consumer is ready, search starts just past the last winner.
module bar_rr_arb #(
    parameter int N  = 4,
    parameter int DW = 32
) (
    input  logic       clk,
    input  logic       rst,
    bar_rr_arb_if.slave bus
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic [DW-1:0] out_data_q,  out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] out_src_q,   out_src_d;
    logic [SW-1:0] ptr_q,       ptr_d;
    logic [15:0]   beat_cnt_q,  beat_cnt_d;

    logic          gnt_vld;
    logic [SW-1:0] gnt_idx;
    logic [DW-1:0] gnt_data;
    logic          slot_free;
    logic          accept;
    logic          drain;
    logic [N-1:0]  rdy;

    // Rotating priority search: first valid requester at or after ptr, wrapping.
    always_comb begin
        logic [SW:0] idx;
        idx     = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = {1'b0, ptr_q} + (SW+1)'(k);
            if (idx >= (SW+1)'(N)) begin
                idx = idx - (SW+1)'(N);
            end
            if (!gnt_vld && bus.in_valid[idx[SW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx[SW-1:0];
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_idx == SW'(i)) begin
                gnt_data = bus.in_data[i*DW +: DW];
            end
        end
    end

    assign slot_free = !out_valid_q || bus.out_ready;
    // Reset gating keeps in_ready low while rst is held, even with the slot empty.
    assign accept    = gnt_vld && slot_free && !rst;
    assign drain     = out_valid_q && bus.out_ready;

    always_comb begin
        rdy = '0;
        if (accept) begin
            rdy[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
        beat_cnt_d  = beat_cnt_q;
        if (accept) begin
            out_data_d  = gnt_data;
            out_src_d   = gnt_idx;
            out_valid_d = 1'b1;
            ptr_d       = (gnt_idx == SW'(N-1)) ? '0 : gnt_idx + SW'(1);
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
        if (drain) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            ptr_q       <= '0;
            beat_cnt_q  <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_src   = out_src_q;
    assign bus.beat_cnt  = beat_cnt_q;
endmodule
